// File: rtl/alpha_scroller_if.sv
// Character load port for alpha_scroller: valid/ready handshake with end-of-message marker.
interface alpha_scroller_if;
  logic       load_valid;
  logic       load_ready;
  logic [4:0] load_char;
  logic       load_last;

  modport master (output load_valid, output load_char, output load_last, input load_ready);
  modport slave  (input load_valid, input load_char, input load_last, output load_ready);
endinterface

// File: rtl/alpha_scroller.sv
// Alphabetic seven-segment message driver: buffered load port, static or right-to-left marquee display.
// Optional feature macro ALPHA_SCROLL_BLINK_EN: static messages blink on every step.
module alpha_scroller #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned MSG_LEN  = 16,
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alpha_scroller_if.slave       ld,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  mode,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned PTR_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned LEN_W  = $clog2(MSG_LEN + 1);
  localparam int unsigned IDX_W  = LEN_W + 1;
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned HEX_W  = 7 * DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  logic [1:0]        state_q, state_d;
  logic [4:0]        buf_q [MSG_LEN];
  logic [4:0]        buf_d [MSG_LEN];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PTR_W-1:0]  pos_q, pos_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [HEX_W-1:0]  hex_q, hex_d;
  logic              xfer;
  logic              step;
  logic              scroll_act;
  logic              blink_off;
  logic [IDX_W-1:0]  idx;

`ifdef ALPHA_SCROLL_BLINK_EN
  logic blink_q, blink_d;
  assign blink_off = blink_q;
`else
  assign blink_off = 1'b0;
`endif

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'b0001000;
      5'd1:    glyph = 7'b0000011;
      5'd2:    glyph = 7'b1000110;
      5'd3:    glyph = 7'b0100001;
      5'd4:    glyph = 7'b0000110;
      5'd5:    glyph = 7'b0001110;
      5'd6:    glyph = 7'b0010000;
      5'd7:    glyph = 7'b0001011;
      5'd8:    glyph = 7'b1111001;
      5'd9:    glyph = 7'b1110001;
      5'd10:   glyph = 7'b0001010;
      5'd11:   glyph = 7'b1000111;
      5'd12:   glyph = 7'b1101010;
      5'd13:   glyph = 7'b0101011;
      5'd14:   glyph = 7'b0100011;
      5'd15:   glyph = 7'b0001100;
      5'd16:   glyph = 7'b0011000;
      5'd17:   glyph = 7'b0101111;
      5'd18:   glyph = 7'b0010010;
      5'd19:   glyph = 7'b0000111;
      5'd20:   glyph = 7'b1000001;
      5'd21:   glyph = 7'b1100011;
      5'd22:   glyph = 7'b1010101;
      5'd23:   glyph = 7'b0001001;
      5'd24:   glyph = 7'b0010001;
      5'd25:   glyph = 7'b0100100;
      5'd27:   glyph = 7'b0111111;
      5'd28:   glyph = 7'b1110111;
      default: glyph = GLYPH_BLANK;
    endcase
  endfunction

  assign ld.load_ready = reset_n && !clear && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign xfer          = ld.load_valid && ld.load_ready;
  assign scroll_act    = mode && (len_q > LEN_W'(DIGITS));
  assign hex           = hex_q;

  // Next-state: load sequencing, step timing and marquee position
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    pos_d    = pos_q;
    tick_d   = tick_q;
    step     = 1'b0;
`ifdef ALPHA_SCROLL_BLINK_EN
    blink_d  = blink_q;
`endif
    if (clear) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      len_d    = '0;
      pos_d    = '0;
      tick_d   = '0;
`ifdef ALPHA_SCROLL_BLINK_EN
      blink_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (xfer) begin
            buf_d[wr_ptr_q] = ld.load_char;
            if (ld.load_last || (wr_ptr_q == PTR_W'(MSG_LEN - 1))) begin
              state_d  = ST_SHOW;
              len_d    = LEN_W'(wr_ptr_q) + LEN_W'(1);
              wr_ptr_d = '0;
              pos_d    = '0;
              tick_d   = '0;
`ifdef ALPHA_SCROLL_BLINK_EN
              blink_d  = 1'b0;
`endif
            end else begin
              state_d  = ST_LOAD;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
          end
        end
        ST_SHOW: begin
          if (enable) begin
            if (tick_q == TICK_W'(TICK_DIV - 1)) begin
              tick_d = '0;
              step   = 1'b1;
            end else begin
              tick_d = tick_q + TICK_W'(1);
            end
          end
          if (step && scroll_act) begin
            pos_d = (pos_q == PTR_W'(len_q - LEN_W'(1))) ? '0 : pos_q + PTR_W'(1);
          end
`ifdef ALPHA_SCROLL_BLINK_EN
          else if (step) begin
            blink_d = !blink_q;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Display window from the current buffer state; registered one cycle later
  always_comb begin
    hex_d = '1;
    idx   = '0;
    if (!clear && (state_q == ST_SHOW)) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        idx = IDX_W'(pos_q) + IDX_W'(i);
        if (idx >= IDX_W'(len_q)) begin
          idx = idx - IDX_W'(len_q);
        end
        if (scroll_act) begin
          hex_d[7*(int'(DIGITS)-1-i) +: 7] = glyph(buf_q[idx[PTR_W-1:0]]);
        end else if ((IDX_W'(i) < IDX_W'(len_q)) && !blink_off) begin
          hex_d[7*(int'(DIGITS)-1-i) +: 7] = glyph(buf_q[PTR_W'(i)]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      pos_q    <= '0;
      tick_q   <= '0;
      hex_q    <= '1;
`ifdef ALPHA_SCROLL_BLINK_EN
      blink_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      hex_q    <= hex_d;
`ifdef ALPHA_SCROLL_BLINK_EN
      blink_q  <= blink_d;
`endif
    end
  end

  // Message storage needs no reset: only entries below len are ever displayed
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_alpha_scroller.sv
// Bench for alpha_scroller: message-level reference model checked every cycle, plus literal glyph windows.
`timescale 1ns/1ps
module tb_alpha_scroller;
  localparam int unsigned DIGITS   = 6;
  localparam int unsigned MSG_LEN  = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned HW       = 7 * DIGITS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic [HW-1:0] hex;

  alpha_scroller_if ld();

  alpha_scroller #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .ld(ld.slave), .clear(clear),
    .enable(enable), .mode(mode), .hex(hex)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  function automatic logic [6:0] glyph(input int c);
    case (c)
      0: return 7'b0001000;   1: return 7'b0000011;   2: return 7'b1000110;
      3: return 7'b0100001;   4: return 7'b0000110;   5: return 7'b0001110;
      6: return 7'b0010000;   7: return 7'b0001011;   8: return 7'b1111001;
      9: return 7'b1110001;  10: return 7'b0001010;  11: return 7'b1000111;
      12: return 7'b1101010; 13: return 7'b0101011;  14: return 7'b0100011;
      15: return 7'b0001100; 16: return 7'b0011000;  17: return 7'b0101111;
      18: return 7'b0010010; 19: return 7'b0000111;  20: return 7'b1000001;
      21: return 7'b1100011; 22: return 7'b1010101;  23: return 7'b0001001;
      24: return 7'b0010001; 25: return 7'b0100100;  27: return 7'b0111111;
      28: return 7'b1110111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: the message as a queue, a display offset and a step counter
  int            msg[$];
  bit            m_show = 1'b0;
  int            m_pos = 0;
  int            m_tick = 0;
  bit            m_phase = 1'b0;
  logic [HW-1:0] exp_hex = '1;
  bit            chk_en = 1'b0;

  function automatic logic [HW-1:0] view();
    logic [HW-1:0] v;
    int len;
    bit scr;
    v   = '1;
    len = msg.size();
    scr = mode && (len > int'(DIGITS));
    if (!m_show) return v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scr) v[7*(int'(DIGITS)-1-i) +: 7] = glyph(msg[(m_pos + i) % len]);
      else if (i < len && !m_phase) v[7*(int'(DIGITS)-1-i) +: 7] = glyph(msg[i]);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    logic [HW-1:0] nxt;
    if (!reset_n) begin
      msg.delete(); m_show = 1'b0; m_pos = 0; m_tick = 0; m_phase = 1'b0;
      exp_hex = '1; chk_en = 1'b1;
    end else begin
      nxt = clear ? '1 : view();
      if (clear) begin
        msg.delete(); m_show = 1'b0; m_pos = 0; m_tick = 0; m_phase = 1'b0;
      end else if (!m_show) begin
        if (ld.load_valid) begin
          msg.push_back(int'(ld.load_char));
          if (ld.load_last || msg.size() == int'(MSG_LEN)) begin
            m_show = 1'b1; m_pos = 0; m_tick = 0; m_phase = 1'b0;
          end
        end
      end else if (enable) begin
        m_tick++;
        if (m_tick == int'(TICK_DIV)) begin
          m_tick = 0;
          if (mode && msg.size() > int'(DIGITS)) m_pos = (m_pos + 1) % msg.size();
`ifdef ALPHA_SCROLL_BLINK_EN
          else m_phase = !m_phase;
`endif
        end
      end
      exp_hex = nxt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_hex", hex, exp_hex);
      check("model_ready", HW'(ld.load_ready), HW'(reset_n && !clear && !m_show));
    end
  end

  task automatic send(input int c, input bit last);
    ld.load_valid = 1'b1; ld.load_char = 5'(c); ld.load_last = last;
    @(posedge clk); #1;
    ld.load_valid = 1'b0; ld.load_last = 1'b0;
  endtask

  task automatic show_after(input int edges);
    repeat (edges) @(posedge clk);
    @(negedge clk);
  endtask

  logic [HW-1:0] win_hello, win_a0, win_a1, win_long, win_ab, all_blank;

  initial begin
    win_hello = {7'h0B, 7'h06, 7'h47, 7'h47, 7'h23, 7'h7F};
    win_a0    = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    win_a1    = {7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h10};
    win_long  = {7'h2B, 7'h23, 7'h0C, 7'h18, 7'h2F, 7'h12};
    win_ab    = {7'h08, 7'h03, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    all_blank = '1;
    ld.load_valid = 1'b0; ld.load_char = '0; ld.load_last = 1'b0;

    // Reset held for three edges
    @(negedge clk);
    check("reset_hex", hex, all_blank);
    check("reset_ready", HW'(ld.load_ready), HW'(0));
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", HW'(ld.load_ready), HW'(1));

    // Static "hELLo"
    mode = 1'b0; enable = 1'b1;
    send(7, 0); send(4, 0); send(11, 0); send(11, 0); send(14, 1);
    show_after(1);
    check("hello_first", hex, win_hello);
    check("hello_ready", HW'(ld.load_ready), HW'(0));
    show_after(20);
`ifdef ALPHA_SCROLL_BLINK_EN
    check("hello_blink_blank", hex, all_blank);
`else
    check("hello_steady", hex, win_hello);
`endif

    // clear while showing
    clear = 1'b1;
    show_after(1);
    check("clear_show_hex", hex, all_blank);
    clear = 1'b0;

    // Marquee of codes 0..7
    mode = 1'b1;
    for (int i = 0; i < 8; i++) send(i, i == 7);
    show_after(1);
    check("scroll_win0", hex, win_a0);
    show_after(4);
    check("scroll_win1", hex, win_a1);
    show_after(28);
    check("scroll_wrap", hex, win_a0);
    enable = 1'b0;
    show_after(10);
    check("scroll_frozen", hex, win_a0);
    enable = 1'b1;
    show_after(9);
    mode = 1'b0;
    show_after(6);
    mode = 1'b1;

    // 16 characters without load_last, then a 17th attempt
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    mode = 1'b0;
    for (int i = 0; i < 16; i++) send(i + 13, 0);
    ld.load_valid = 1'b1; ld.load_char = 5'd0;
    show_after(1);
    check("full_first", hex, win_long);
    check("full_ready", HW'(ld.load_ready), HW'(0));
    show_after(2);
    ld.load_valid = 1'b0;
    mode = 1'b1;
    show_after(70);

    // clear beats a simultaneous transfer in LOAD
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    send(3, 0); send(4, 0);
    ld.load_valid = 1'b1; ld.load_char = 5'd5; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; ld.load_valid = 1'b0;
    @(negedge clk);
    check("clear_load_hex", hex, all_blank);
    check("clear_load_ready", HW'(ld.load_ready), HW'(1));
    mode = 1'b0;
    send(0, 0); send(1, 1);
    show_after(1);
    check("reload_win", hex, win_ab);
    show_after(4);
`ifdef ALPHA_SCROLL_BLINK_EN
    check("short_phase2", hex, all_blank);
`else
    check("short_phase2", hex, win_ab);
`endif
    show_after(4);
    check("short_phase3", hex, win_ab);
    enable = 1'b0;
    show_after(12);
    check("short_frozen", hex, win_ab);
    enable = 1'b1;
    show_after(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
